// File: rtl/rt_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : rt_timer_sched
// Brief    : Per-flow retransmit timers; scans for expiries and issues
//            retransmit-set commands to the scheduler update port.
// Revision : 1.0 - initial release
// ============================================================================
module rt_timer_sched #(
   parameter int TIMEOUT_W   = 16,
   parameter int TICK_CYCLES = 1024,
   parameter int NUM_FLOWS   = 64,   // MAX_TCP_FLOWS
   localparam int FLOWID_W   = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1,
   localparam int SCHED_CMD_STRUCT_W = FLOWID_W + 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          timer_cmd_val,
   input  logic [FLOWID_W-1:0]           timer_cmd_flowid,
   input  logic                          timer_cmd_arm,
   input  logic [TIMEOUT_W-1:0]          timer_cmd_timeout,
   output logic                          timer_cmd_rdy,
   output logic                          sched_update_val,
   output logic [SCHED_CMD_STRUCT_W-1:0] sched_update_cmd,
   input  logic                          sched_update_rdy
);

   localparam logic [1:0] c_PEND_NOP = 2'b00;
   localparam logic [1:0] c_PEND_SET = 2'b01;
   localparam int c_PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_CYCLES - 1);
   localparam logic [FLOWID_W-1:0]  c_PTR_MAX   = FLOWID_W'(NUM_FLOWS - 1);

   typedef struct packed {
      logic [FLOWID_W-1:0] flowid;
      logic [1:0]          rt_pend_set_clear;
      logic [1:0]          ack_pend_set_clear;
      logic [1:0]          data_pend_set_clear;
   } sched_cmd_t;

   typedef enum logic [0:0] {
      SCAN  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [c_PRESC_W-1:0]   r_presc;
   logic [TIMEOUT_W-1:0]   r_now;
   logic [NUM_FLOWS-1:0]   r_armed;
   logic [TIMEOUT_W-1:0]   r_deadline [NUM_FLOWS];
   logic [FLOWID_W-1:0]    r_ptr;
   sched_cmd_t             r_cmd;

   logic                   w_cmd_acc;
   logic                   w_cmd_in_range;
   logic                   w_tick;
   logic [TIMEOUT_W-1:0]   w_age;
   logic                   w_expired;
   logic [FLOWID_W-1:0]    w_ptr_inc;
   logic                   w_load;
   logic                   w_adv;

   assign timer_cmd_rdy    = ~rst;
   assign w_cmd_acc        = timer_cmd_val & timer_cmd_rdy;
   assign w_cmd_in_range   = 32'(timer_cmd_flowid) < NUM_FLOWS;
   assign w_tick           = (r_presc == c_PRESC_MAX);
   // Wrap-safe compare: expired once now has caught up with the deadline
   assign w_age            = r_now - r_deadline[r_ptr];
   assign w_expired        = r_armed[r_ptr] & ~w_age[TIMEOUT_W-1];
   assign w_ptr_inc        = (r_ptr == c_PTR_MAX) ? '0 : r_ptr + 1'b1;
   assign sched_update_cmd = r_cmd;

   always_comb begin
      w_state_nxt      = r_state;
      w_load           = 1'b0;
      w_adv            = 1'b0;
      sched_update_val = 1'b0;
      case (r_state)
         SCAN: begin
            // A command write owns the entry arrays this cycle; scan stalls
            if (!w_cmd_acc) begin
               if (w_expired) begin
                  w_load      = 1'b1;
                  w_state_nxt = ISSUE;
               end else begin
                  w_adv = 1'b1;
               end
            end
         end
         ISSUE: begin
            sched_update_val = 1'b1;
            if (sched_update_rdy) begin
               w_adv       = 1'b1;
               w_state_nxt = SCAN;
            end
         end
         default: w_state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SCAN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
         r_now   <= '0;
         r_ptr   <= '0;
         r_armed <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) begin
            r_now <= r_now + 1'b1;
         end
         if (w_adv) begin
            r_ptr <= w_ptr_inc;
         end
         if (w_load) begin
            r_armed[r_ptr] <= 1'b0;
         end
         if (w_cmd_acc && w_cmd_in_range) begin
            r_armed[timer_cmd_flowid] <= timer_cmd_arm;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_cmd_acc && w_cmd_in_range && timer_cmd_arm) begin
         r_deadline[timer_cmd_flowid] <= r_now + timer_cmd_timeout;
      end
   end

   always_ff @(posedge clk) begin
      if (w_load) begin
         r_cmd.flowid              <= r_ptr;
         r_cmd.rt_pend_set_clear   <= c_PEND_SET;
         r_cmd.ack_pend_set_clear  <= c_PEND_NOP;
         r_cmd.data_pend_set_clear <= c_PEND_NOP;
      end
   end

endmodule
`default_nettype wire
